// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared types and constants for the ADC capture sequencer
package adc_capture_pkg;

  // Sample width produced by the AD9228 deserializer cores
  localparam int ADC_DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } capture_state_t;

  // Width of a channel index; never narrower than one bit
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_capture_sequencer_rr_arbiter.sv
// rtl/adc_capture_sequencer_rr_arbiter.sv - round-robin arbiter over per-channel pending bits
module rr_arbiter
  import adc_capture_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = ch_idx_w(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_i,
  input  logic          advance_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_valid_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;

  // Pick the first requester at or after the pointer, wrapping around
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int off = 0; off < N; off++) begin
      idx = IW'((int'(ptr_q) + off) % N);
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_o[idx]  = 1'b1;
        grant_idx_o   = idx;
      end
    end
  end

  // Priority restarts at the channel after the last taken grant
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else if (clr_i) begin
      ptr_q <= '0;
    end else if (advance_i && grant_valid_o) begin
      ptr_q <= (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + IW'(1);
    end
  end

endmodule

// File: rtl/adc_capture_sequencer.sv
// rtl/adc_capture_sequencer.sv - frame-counted capture run merging four ADC channels onto one stream
module adc_capture_sequencer
  import adc_capture_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         abort,
  input  logic [CNT_WIDTH-1:0]         num_frames,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            ch_strobe,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [ch_idx_w(NUM_CH)-1:0]  m_chan,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_CH-1:0]            overflow,
  output logic [CNT_WIDTH-1:0]         frame_count
);

  localparam int CW = ch_idx_w(NUM_CH);

  capture_state_t        state_q, state_d;
  logic [NUM_CH-1:0]     en_q, ref_oh;
  logic [CNT_WIDTH-1:0]  nfr_q, fcnt_q, fcnt_d;
  logic [NUM_CH-1:0]     pend_q, pend_d, ovf_q, ovf_d;
  logic [NUM_CH-1:0]     acc, drop, load, grant, grant_eff, pend_rest;
  logic [DATA_WIDTH-1:0] hold_q [NUM_CH];
  logic [CW-1:0]         grant_idx;
  logic                  grant_valid, grant_go, hold_last, last_d;
  logic                  start_acc, abort_now, ref_strb, final_frame, out_free;
  logic                  mval_q, mlast_q, busy_q, done_q, done_d;
  logic [DATA_WIDTH-1:0] mdata_q;
  logic [CW-1:0]         mchan_q;

  assign start_acc   = start && (state_q == ST_IDLE);
  assign abort_now   = abort && (state_q != ST_IDLE);
  assign ref_oh      = en_q & (~en_q + NUM_CH'(1));
  assign ref_strb    = |(ch_strobe & ref_oh);
  assign final_frame = (fcnt_q == nfr_q);
  assign out_free    = !mval_q || m_ready;

  // In the final frame more non-reference samples may still arrive, so the
  // last pending sample is held back until the closing reference strobe
  // moves us to DRAIN; only then can it be tagged as the final beat.
  assign hold_last = (state_q == ST_CAPTURE) && final_frame &&
                     (pend_q != '0) && ((pend_q & (pend_q - NUM_CH'(1))) == '0);
  assign grant_go  = out_free && grant_valid && !hold_last && !abort_now;
  assign grant_eff = grant_go ? grant : '0;
  assign pend_rest = pend_q & ~grant_eff;
  assign last_d    = (state_q == ST_DRAIN) && (pend_rest == '0);

  rr_arbiter #(.N(NUM_CH), .IW(CW)) u_arb (
    .clk          (clk),
    .rstn         (rstn),
    .clr_i        (start_acc),
    .advance_i    (grant_go),
    .req_i        (pend_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .grant_valid_o(grant_valid)
  );

  // Run FSM: alignment on the reference channel, frame counting, drain and abort
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    acc     = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          fcnt_d = '0;
          if ((ch_enable == '0) || (num_frames == '0)) done_d = 1'b1;
          else state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (ref_strb) begin
          acc     = ch_strobe & en_q;
          fcnt_d  = CNT_WIDTH'(1);
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (ref_strb && final_frame) begin
          state_d = ST_DRAIN;
        end else begin
          acc = ch_strobe & en_q;
          if (ref_strb) fcnt_d = fcnt_q + CNT_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (mval_q && m_ready && mlast_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_now) begin
      state_d = ST_IDLE;
      acc     = '0;
      done_d  = 1'b0;
    end
  end

  // A strobe onto a still-pending channel that is not being granted is lost
  assign drop   = acc & pend_q & ~grant_eff;
  assign load   = acc & ~drop;
  assign pend_d = abort_now ? '0 : (pend_rest | load);
  assign ovf_d  = start_acc ? '0 : (ovf_q | drop);

  // Control registers, configuration latched on an accepted start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      en_q    <= '0;
      nfr_q   <= '0;
      fcnt_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      if (start_acc) begin
        en_q  <= ch_enable;
        nfr_q <= num_frames;
      end
    end
  end

  // Per-channel holding registers, one sample deep
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) hold_q[i] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output beat register; payload only changes when a new grant is loaded
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mval_q  <= 1'b0;
      mlast_q <= 1'b0;
      mdata_q <= '0;
      mchan_q <= '0;
    end else if (abort_now) begin
      mval_q  <= 1'b0;
      mlast_q <= 1'b0;
    end else if (grant_go) begin
      mval_q  <= 1'b1;
      mdata_q <= hold_q[grant_idx];
      mchan_q <= grant_idx;
      mlast_q <= last_d;
    end else if (m_ready) begin
      mval_q  <= 1'b0;
      mlast_q <= 1'b0;
    end
  end

  assign m_valid     = mval_q;
  assign m_data      = mdata_q;
  assign m_chan      = mchan_q;
  assign m_last      = mlast_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb/tb_adc_capture_sequencer.sv - scoreboard bench for adc_capture_sequencer
module tb_adc_capture_sequencer;

  typedef struct packed {
    logic [1:0]  ch;
    logic [11:0] data;
    logic        is_last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, abort, m_ready;
  logic [15:0] num_frames;
  logic [3:0]  ch_enable, ch_strobe;
  logic [47:0] ch_data;
  logic        m_valid, m_last, busy, done;
  logic [11:0] m_data;
  logic [1:0]  m_chan;
  logic [3:0]  overflow;
  logic [15:0] frame_count;

  int    errors = 0;
  int    checks = 0;
  beat_t sb [$];

  adc_capture_sequencer #(.NUM_CH(4), .DATA_WIDTH(12), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .num_frames (num_frames),
    .ch_enable  (ch_enable),
    .ch_strobe  (ch_strobe),
    .ch_data    (ch_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_chan     (m_chan),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] en, input logic [15:0] nf);
    ch_enable  = en;
    num_frames = nf;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  // Drive one strobe cycle; channels in push are expected on the stream in
  // ascending channel order, last_ch marks the beat that must carry m_last
  task automatic strobe(input logic [3:0] mask, input logic [3:0] push, input int last_ch);
    logic [11:0] d [4];
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      d[i] = 12'($urandom);
      ch_data[i*12 +: 12] = d[i];
    end
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        b.ch      = 2'(i);
        b.data    = d[i];
        b.is_last = (i == last_ch);
        sb.push_back(b);
      end
    end
    ch_strobe = mask;
    tick(1);
    ch_strobe = '0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  // Stream monitor: payload stability under stall and in-order scoreboard compare
  logic        stall_q = 1'b0;
  logic [11:0] st_data;
  logic [1:0]  st_chan;
  logic        st_last;
  always @(negedge clk) begin
    beat_t e;
    if (rstn !== 1'b1) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && m_valid) begin
        check("stall_data", 32'(m_data), 32'(st_data));
        check("stall_chan", 32'(m_chan), 32'(st_chan));
        check("stall_last", 32'(m_last), 32'(st_last));
      end
      if (m_valid && m_ready) begin
        check("beat_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("beat_chan", 32'(m_chan), 32'(e.ch));
          check("beat_data", 32'(m_data), 32'(e.data));
          check("beat_last", 32'(m_last), 32'(e.is_last));
        end
      end
      stall_q = m_valid && !m_ready;
      st_data = m_data;
      st_chan = m_chan;
      st_last = m_last;
    end
  end

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    num_frames = '0; ch_enable = '0; ch_strobe = '0; ch_data = '0;
    tick(2);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_chan", 32'(m_chan), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    rstn = 1'b1;
    tick(2);

    // Basic run: four channels, two frames
    pulse_start(4'b1111, 16'd2);
    check("basic_busy", 32'(busy), 32'd1);
    tick(1);
    strobe(4'b1111, 4'b1111, -1);
    tick(5);
    strobe(4'b1111, 4'b1111, 3);
    tick(5);
    strobe(4'b1111, 4'b0000, -1);
    wait_done("basic_done");
    check("basic_frames", 32'(frame_count), 32'd2);
    check("basic_overflow", 32'(overflow), 32'd0);
    check("basic_sb_empty", 32'(sb.size()), 32'd0);
    tick(1);
    check("basic_done_pulse", 32'(done), 32'd0);
    check("basic_idle", 32'(busy), 32'd0);

    // Backpressure: stall output for about 20 cycles
    m_ready = 1'b0;
    pulse_start(4'b1111, 16'd3);
    tick(1);
    strobe(4'b1111, 4'b1111, -1);
    tick(5);
    strobe(4'b1111, 4'b0001, 0);
    tick(5);
    strobe(4'b1111, 4'b0000, -1);
    tick(5);
    check("bp_overflow", 32'(overflow), 32'hF);
    check("bp_stalled", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    tick(10);
    check("bp_frames", 32'(frame_count), 32'd3);
    strobe(4'b1111, 4'b0000, -1);
    wait_done("bp_done");
    check("bp_overflow_kept", 32'(overflow), 32'hF);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);
    tick(2);

    // Alignment and mask: early non-reference strobe is discarded
    pulse_start(4'b1010, 16'd1);
    check("align_ovf_cleared", 32'(overflow), 32'd0);
    tick(1);
    strobe(4'b1000, 4'b0000, -1);
    tick(2);
    strobe(4'b1111, 4'b1010, 3);
    tick(5);
    check("align_busy", 32'(busy), 32'd1);
    strobe(4'b1111, 4'b0000, -1);
    wait_done("align_done");
    check("align_frames", 32'(frame_count), 32'd1);
    check("align_overflow", 32'(overflow), 32'd0);
    check("align_sb_empty", 32'(sb.size()), 32'd0);
    tick(2);

    // Zero frames and empty mask complete immediately
    pulse_start(4'b1111, 16'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    tick(1);
    check("zero_done_pulse", 32'(done), 32'd0);
    check("zero_busy_after", 32'(busy), 32'd0);
    pulse_start(4'b0000, 16'd4);
    check("nomask_done", 32'(done), 32'd1);
    check("nomask_busy", 32'(busy), 32'd0);
    tick(2);

    // Abort while a beat is stalled on the output
    m_ready = 1'b0;
    pulse_start(4'b1111, 16'd5);
    tick(1);
    strobe(4'b1111, 4'b0000, -1);
    tick(2);
    check("abort_pre_valid", 32'(m_valid), 32'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_valid", 32'(m_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_frames_kept", 32'(frame_count), 32'd1);
    tick(1);
    check("abort_no_done_late", 32'(done), 32'd0);
    m_ready = 1'b1;
    tick(3);
    pulse_start(4'b1111, 16'd1);
    tick(1);
    strobe(4'b1111, 4'b1111, 3);
    tick(5);
    strobe(4'b1111, 4'b0000, -1);
    wait_done("post_abort_done");
    check("post_abort_sb_empty", 32'(sb.size()), 32'd0);
    tick(2);

    // Grant/strobe collision on channel 2
    pulse_start(4'b0100, 16'd3);
    tick(1);
    strobe(4'b0100, 4'b0100, -1);
    strobe(4'b0100, 4'b0100, -1);
    tick(4);
    strobe(4'b0100, 4'b0100, 2);
    tick(4);
    check("coll_overflow", 32'(overflow), 32'd0);
    strobe(4'b0100, 4'b0000, -1);
    wait_done("coll_done");
    check("coll_frames", 32'(frame_count), 32'd3);
    check("coll_overflow_end", 32'(overflow), 32'd0);
    check("coll_sb_empty", 32'(sb.size()), 32'd0);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Sequences a capture run across the four channels of one AD9228 quad ADC. Runs in the system `clk` domain, downstream of the per-channel deserializer cores. Accepts each channel's `read_complete` strobe and parallel word, and buffers one sample per channel. A round-robin arbiter merges all channels onto a single channel-tagged stream toward the capture FIFO, and the block stops after a programmed number of frames.

## Interface
- `NUM_CH`, 4: channel count.
- `DATA_WIDTH`, 12: sample width.
- `CNT_WIDTH`, 16: frame counter width.

Ports (clock and reset first):
- `clk`, in, 1: system clock. Reset `rstn` is asynchronous, active-low; clock is `clk`.
- `rstn`, in, 1: asynchronous active-low reset.
- `start`, in, 1: single-cycle run request; ignored unless state is IDLE.
- `abort`, in, 1: single-cycle; forces IDLE from any state.
- `num_frames`, in, `CNT_WIDTH`: frames per run; sampled on accepted `start`.
- `ch_enable`, in, `NUM_CH`: channel mask; sampled on accepted `start`.
- `ch_strobe`, in, `NUM_CH`: per-channel `read_complete` pulses, already in `clk` domain.
- `ch_data`, in, `NUM_CH*DATA_WIDTH`: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; valid in the strobe cycle.
- `m_valid`, out, 1: output beat valid.
- `m_ready`, in, 1: output beat accepted.
- `m_data`, out, `DATA_WIDTH`: output sample.
- `m_chan`, out, `$clog2(NUM_CH)`: source channel of the beat.
- `m_last`, out, 1: final beat of the run.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: one-cycle pulse when a run completes normally.
- `overflow`, out, `NUM_CH`: sticky per-channel drop flags; cleared on accepted `start`.
- `frame_count`, out, `CNT_WIDTH`: frames accepted in the current or last run.

## Operation
- States are IDLE, ALIGN, CAPTURE, DRAIN.
- The reference channel is the lowest-index set bit of the latched `ch_enable`.
- An all-zero mask, or `num_frames` = 0, on `start` produces a `done` pulse on the next cycle and the block stays IDLE.
- IDLE → ALIGN on accepted `start`. The latch clears `overflow` and `frame_count` and resets the round-robin pointer to channel 0.
- ALIGN discards all strobes until the first reference strobe.
  - That strobe is accepted, and `frame_count` becomes 1.
  - The state moves to CAPTURE.
  - Non-reference strobes in the same cycle are also accepted.
- CAPTURE accepts strobes of enabled channels into per-channel holding registers and sets each channel's pending bit.
  - Each reference strobe while `frame_count` < `num_frames` increments `frame_count`.
  - A reference strobe when `frame_count` == `num_frames` → DRAIN. That strobe, and every strobe from that cycle on, is ignored.
- A strobe on a channel whose pending bit is set, and which is not being granted this cycle, is dropped. The held sample is kept and `overflow[i]` is set.
- A strobe in the same cycle its channel is granted is accepted without overflow.
- Arbiter:
  - Round-robin over pending bits, with priority starting at the channel after the last grant.
  - A grant happens when the output register is empty, or is being emptied (`m_valid` && `m_ready`).
  - A grant clears that channel's pending bit.
- DRAIN continues granting until no bits are pending and the output register is empty.
  - `m_last` is asserted with the beat loaded when the state is DRAIN and no other bits are pending.
  - After the `m_last` handshake the block goes to IDLE, with `done` high for one cycle.
- `abort` in any non-IDLE state, on the next edge:
  - goes to IDLE;
  - clears pending bits and `m_valid`;
  - does not pulse `done`;
  - keeps `overflow` and `frame_count`.
- Stream rules: `m_data`, `m_chan` and `m_last` are stable while `m_valid` && !`m_ready`. `abort` is the only permitted withdrawal of `m_valid`.

## Timing
- Strobe sampled at edge N; holding register loaded at edge N.
- With the output empty and no competing pending bits, the grant loads the output at edge N+1, so `m_valid` is high after edge N+1. Strobe-to-`m_valid` latency is 2 edges.
- Sustained throughput is one beat per cycle while `m_ready` = 1.
- `done` is high in the cycle after the edge that completes the `m_last` handshake.
- Reset values:
  - state IDLE;
  - `m_valid`, `m_last`, `busy`, `done` = 0;
  - `m_data`, `m_chan` = 0;
  - `overflow` = 0, `frame_count` = 0;
  - pending bits and round-robin pointer = 0.
- `busy` is registered and goes high the cycle after `start`.

## Structure
- Package `adc_capture_pkg` holds:
  - the state enum `capture_state_t`;
  - the channel-index width function;
  - the `DATA_WIDTH` default constant, shared with the deserializer cores.
- Sub-module `rr_arbiter` (parameter N): pending vector in, one-hot grant and index out, with an advance-pointer input.
- The top level contains the FSM, counter, holding registers, overflow logic and output register.

## Test plan
- **Basic run:** all channels enabled, `num_frames` = 2, strobes on channels 0-3 together every 6 cycles, `m_ready` = 1 → 8 beats, `m_chan` 0,1,2,3,0,1,2,3. `m_last` on the 8th beat, then `done`. `frame_count` = 2, `overflow` = 0.
- **Backpressure:** `m_ready` = 0 for 20 cycles with strobes every 6 cycles → `overflow` = 4'b1111. The first-held samples are emitted unchanged after `m_ready` rises, and `m_data` is stable throughout the stall.
- **Alignment and mask:** `ch_enable` = 4'b1010, non-reference channel 3 strobes before the first channel-1 strobe → the early channel-3 sample is discarded. Only channels 1 and 3 appear, and channel 1 acts as the reference.
- **Zero frames:** `num_frames` = 0 → `done` the cycle after `start`, no beats, `busy` stays 0.
- **Abort:** `abort` during CAPTURE with `m_valid` = 1 → `m_valid` = 0 on the next cycle and IDLE, no `done`. A subsequent `start` runs normally.
- **Grant/strobe collision:** channel 2 is pending, granted in the same cycle its next strobe arrives → no overflow, and both samples are emitted in order.
